// File: rtl/krake_intercon.sv
// rtl/krake_intercon.sv - single-master to NUM_SLAVES strobe/ack bus intercon with error tracking
//
// Optional feature: define INTERCON_TIMEOUT_EN to add an ack-wait timeout of TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-low reset
//   m_stb_i/m_we_i         master strobe (held until ack/err) and write enable
//   m_adr_i/m_dat_i        master address (top 4 bits select slave) and write data
//   m_dat_o                registered read data, updated only on a read ack
//   m_ack_o/m_err_o        one-cycle completion / bus-error pulses
//   s_stb_o                per-slave strobe, one-hot or zero
//   s_we_o/s_adr_o/s_dat_o registered broadcast of the latched master cycle
//   s_ack_i/s_dat_i        per-slave acks and packed read data (slave k at [k*DAT_W +: DAT_W])
//   err_adr_o/err_cnt_o    address of the last errored cycle, saturating error count

module krake_intercon #(
    parameter int NUM_SLAVES = 12,
    parameter int DAT_W      = 8,
    parameter int ADR_W      = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        m_stb_i,
    input  logic                        m_we_i,
    input  logic [ADR_W-1:0]            m_adr_i,
    input  logic [DAT_W-1:0]            m_dat_i,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic                        m_ack_o,
    output logic                        m_err_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic                        s_we_o,
    output logic [ADR_W-5:0]            s_adr_o,
    output logic [DAT_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
    output logic [ADR_W-1:0]            err_adr_o,
    output logic [7:0]                  err_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0]            NS5     = 5'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] STB_ONE = NUM_SLAVES'(1);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1 || TIMEOUT > 255 || ADR_W < 5)
    begin : g_bad_params
        $error("krake_intercon: parameter out of range");
    end

    logic [1:0]       state;
    logic [3:0]       sel;
    logic [3:0]       req_sel;
    logic             req_mapped;
    logic             sel_ack;
    logic [DAT_W-1:0] sel_dat;
    logic [7:0]       err_cnt_inc;
    logic             wait_expired;

    assign req_sel     = m_adr_i[ADR_W-1 -: 4];
    assign req_mapped  = ({1'b0, req_sel} < NS5);
    assign err_cnt_inc = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;

    // Only the latched slave's ack and data are visible; stray acks never match.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel == 4'(k)) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

`ifdef INTERCON_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Cleared whenever outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= 8'd0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Expiry fires on the edge where the count would reach TIMEOUT.
    assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            sel       <= 4'd0;
            s_stb_o   <= '0;
            s_we_o    <= 1'b0;
            s_adr_o   <= '0;
            s_dat_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_dat_o   <= '0;
            err_adr_o <= '0;
            err_cnt_o <= 8'd0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_stb_i) begin
                        sel     <= req_sel;
                        s_we_o  <= m_we_i;
                        s_adr_o <= m_adr_i[ADR_W-5:0];
                        s_dat_o <= m_dat_i;
                        if (req_mapped) begin
                            s_stb_o <= STB_ONE << req_sel;
                            state   <= ST_WAIT;
                        end else begin
                            m_err_o   <= 1'b1;
                            err_adr_o <= m_adr_i;
                            err_cnt_o <= err_cnt_inc;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // Abort beats ack, ack beats a simultaneous timeout.
                    if (!m_stb_i) begin
                        s_stb_o <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ack) begin
                        m_ack_o <= 1'b1;
                        if (!s_we_o) begin
                            m_dat_o <= sel_dat;
                        end
                        s_stb_o <= '0;
                        state   <= ST_DONE;
                    end else if (wait_expired) begin
                        s_stb_o   <= '0;
                        m_err_o   <= 1'b1;
                        err_adr_o <= {sel, s_adr_o};
                        err_cnt_o <= err_cnt_inc;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Held strobe belongs to the finished cycle; wait for its release.
                    if (!m_stb_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_krake_intercon.sv
// tb/tb_krake_intercon.sv - randomized scoreboard bench for krake_intercon

module tb_krake_intercon;

    localparam int NS = 12;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               m_stb_i;
    logic               m_we_i;
    logic [AW-1:0]      m_adr_i;
    logic [DW-1:0]      m_dat_i;
    logic [DW-1:0]      m_dat_o;
    logic               m_ack_o;
    logic               m_err_o;
    logic [NS-1:0]      s_stb_o;
    logic               s_we_o;
    logic [AW-5:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [NS-1:0]      s_ack_i;
    logic [NS*DW-1:0]   s_dat_i;
    logic [AW-1:0]      err_adr_o;
    logic [7:0]         err_cnt_o;

    always #5 clk_i = ~clk_i;

    krake_intercon #(
        .NUM_SLAVES(NS), .DAT_W(DW), .ADR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic       is_err;
        logic [7:0] dat;
        logic [7:0] err_adr;
        logic [7:0] err_cnt;
    } rsp_t;

    typedef struct {
        logic [NS-1:0] stb;
        logic [3:0]    adr;
        logic          we;
        logic [7:0]    dat;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    // Reference model state: what the master should observe.
    logic [7:0] model_dat;
    logic [7:0] model_err_adr;
    int         model_cnt;

    // Slave behaviour: each slave returns slave_data[k]; the selected one acks
    // ack_delay cycles after its strobe rises; stray_on adds random foreign acks.
    logic [7:0] slave_data [NS];
    int         ack_delay;
    bit         stray_on;
    int         age;
    logic [NS-1:0] slv_prev;

    always_comb begin
        s_dat_i = '0;
        for (int k = 0; k < NS; k++) s_dat_i[k*DW +: DW] = slave_data[k];
    end

    always @(posedge clk_i) begin
        #1;
        if (s_stb_o != '0) age = (slv_prev != '0) ? age + 1 : 0;
        slv_prev = s_stb_o;
        s_ack_i = ((s_stb_o != '0 && age == ack_delay) ? s_stb_o : '0)
                | (stray_on ? (NS'($urandom) & ~s_stb_o) : '0);
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or response.
    logic [NS-1:0] mon_prev;
    bus_t mb;
    rsp_t mr;
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (s_stb_o != '0 && mon_prev == '0) begin
                if (bus_q.size() == 0) begin
                    check("stb_unexpected", 32'(s_stb_o), 32'd0);
                end else begin
                    mb = bus_q.pop_front();
                    check("s_stb_o", 32'(s_stb_o), 32'(mb.stb));
                    check("s_adr_o", 32'(s_adr_o), 32'(mb.adr));
                    check("s_we_o",  32'(s_we_o),  32'(mb.we));
                    check("s_dat_o", 32'(s_dat_o), 32'(mb.dat));
                end
            end
            if (m_ack_o || m_err_o) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'({m_ack_o, m_err_o}), 32'd0);
                end else begin
                    mr = rsp_q.pop_front();
                    check("rsp_kind",  32'({m_ack_o, m_err_o}), mr.is_err ? 32'd1 : 32'd2);
                    check("m_dat_o",   32'(m_dat_o),   32'(mr.dat));
                    check("err_adr_o", 32'(err_adr_o), 32'(mr.err_adr));
                    check("err_cnt_o", 32'(err_cnt_o), 32'(mr.err_cnt));
                end
            end
        end
        mon_prev = s_stb_o;
    end

    // Issue one master cycle; fdat >= 0 forces the selected slave's read data.
    task automatic run_txn(input logic [7:0] adr, input logic we, input logic [7:0] wdat,
                           input int delay, input bit stray, input int hold, input int fdat);
        logic [3:0] sel;
        bit   mapped, acks, seen;
        int   exp_lat, lat;
        rsp_t r;
        bus_t b;
        sel    = adr[7:4];
        mapped = int'(sel) < NS;
`ifdef INTERCON_TIMEOUT_EN
        acks = mapped && (delay < TO);
`else
        acks = mapped;
`endif
        for (int k = 0; k < NS; k++) slave_data[k] = 8'($urandom);
        if (mapped && fdat >= 0) slave_data[sel] = 8'(fdat);
        if (mapped) begin
            b.stb = NS'(1) << sel;
            b.adr = adr[3:0];
            b.we  = we;
            b.dat = wdat;
            bus_q.push_back(b);
        end
        if (acks) begin
            if (!we) model_dat = slave_data[sel];
            exp_lat  = delay + 2;
            r.is_err = 1'b0;
        end else begin
            model_err_adr = adr;
            if (model_cnt < 255) model_cnt++;
            exp_lat  = mapped ? TO + 1 : 1;
            r.is_err = 1'b1;
        end
        r.dat     = model_dat;
        r.err_adr = model_err_adr;
        r.err_cnt = 8'(model_cnt);
        rsp_q.push_back(r);
        ack_delay = delay;
        stray_on  = stray;
        @(negedge clk_i);
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_adr_i = adr;
        m_dat_i = wdat;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 2000) begin
            @(negedge clk_i);
            lat++;
            seen = m_ack_o || m_err_o;
        end
        if (seen) check("latency", 32'(lat), 32'(exp_lat));
        else      check("rsp_seen", 32'(m_ack_o | m_err_o), 32'd1);
        repeat (hold) @(negedge clk_i);
        m_stb_i  = 1'b0;
        stray_on = 1'b0;
    endtask

    // Start a cycle that the slave never acks and leave it in WAIT.
    task automatic start_hang(input logic [7:0] adr);
        bus_t b;
        b.stb = NS'(1) << adr[7:4];
        b.adr = adr[3:0];
        b.we  = 1'b0;
        b.dat = 8'h5C;
        bus_q.push_back(b);
        ack_delay = 100000;
        @(negedge clk_i);
        m_stb_i = 1'b1;
        m_we_i  = 1'b0;
        m_adr_i = adr;
        m_dat_i = 8'h5C;
    endtask

    initial begin
        rst_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = '0; ack_delay = 0; stray_on = 1'b0; age = 0; slv_prev = '0; mon_prev = '0;
        for (int k = 0; k < NS; k++) slave_data[k] = 8'h00;
        model_dat = 8'h00; model_err_adr = 8'h00; model_cnt = 0;
        repeat (3) @(negedge clk_i);
        check("rst_s_stb",   32'(s_stb_o),   32'd0);
        check("rst_m_ack",   32'(m_ack_o),   32'd0);
        check("rst_m_err",   32'(m_err_o),   32'd0);
        check("rst_s_we",    32'(s_we_o),    32'd0);
        check("rst_m_dat",   32'(m_dat_o),   32'd0);
        check("rst_s_adr",   32'(s_adr_o),   32'd0);
        check("rst_s_dat",   32'(s_dat_o),   32'd0);
        check("rst_err_adr", 32'(err_adr_o), 32'd0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        run_txn(8'h23, 1'b0, 8'h00, 0, 1'b0, 0, 8'hA5);   // combinational read
        run_txn(8'hC0, 1'b0, 8'h11, 0, 1'b0, 0, -1);      // unmapped
        run_txn(8'h35, 1'b0, 8'h00, 4, 1'b1, 0, -1);      // stray acks, slave 3 late
        run_txn(8'h1F, 1'b1, 8'h77, 2, 1'b0, 3, -1);      // write, held strobe in DONE

`ifdef INTERCON_TIMEOUT_EN
        run_txn(8'h50, 1'b0, 8'h00, TO,     1'b0, 0, -1); // timeout
        run_txn(8'h57, 1'b0, 8'h00, TO - 1, 1'b0, 0, -1); // ack on the expiry edge
`else
        start_hang(8'h50);
        repeat (1000) @(negedge clk_i);
        check("no_timeout_stb", 32'(s_stb_o), 32'(NS'(1) << 5));
        m_stb_i = 1'b0;
        @(negedge clk_i);
`endif

        for (int i = 0; i < 200; i++) begin
`ifdef INTERCON_TIMEOUT_EN
            run_txn(8'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, TO + 2),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3), -1);
`else
            run_txn(8'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3), -1);
`endif
        end

        // Abort: strobe dropped in WAIT, no response expected.
        start_hang(8'h61);
        repeat (4) @(negedge clk_i);
        m_stb_i = 1'b0;
        @(negedge clk_i);
        check("abort_stb", 32'(s_stb_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("abort_bus_q", 32'(bus_q.size()), 32'd0);

        // Asynchronous reset in the middle of WAIT.
        start_hang(8'h3A);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("rst_mid_stb", 32'(s_stb_o), 32'd0);
        check("rst_mid_ack", 32'({m_ack_o, m_err_o}), 32'd0);
        m_stb_i = 1'b0;
        model_dat = 8'h00; model_err_adr = 8'h00; model_cnt = 0;
        @(negedge clk_i);
        check("rst_mid_cnt", 32'(err_cnt_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        run_txn(8'h10, 1'b1, 8'h9E, 1, 1'b0, 0, -1);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            run_txn(8'($urandom_range(8'hC0, 8'hFF)), 1'b0, 8'h00, 0, 1'b0, 0, -1);
        end

        repeat (3) @(negedge clk_i);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
